// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder.
// This package holds the operation codes, the opcode and funct fields, the NOP word and an immediate range helper.
package instr_encoder_pkg;

  // Request operation codes. Codes 5 to 7 are illegal.
  typedef enum logic [2:0] {
    OP_ADDI = 3'd0,
    OP_LW   = 3'd1,
    OP_SRAI = 3'd2,
    OP_SW   = 3'd3,
    OP_BEQ  = 3'd4
  } op_e;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 and funct7 fields.
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SRAI = 3'b101;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  // Canonical NOP (addi x0, x0, 0). It replaces any rejected request.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // The helper returns true when the 32-bit value is a sign-extended BITS-bit number.
  // That is the case when every bit above BITS-1 equals the sign bit.
  function automatic logic imm_fits(input logic [31:0] imm, input int bits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= bits && imm[i] != imm[bits-1]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with valid/ready on both sides.
// The head is read combinationally, so a word written into an empty FIFO shows up on the following cycle.
// The input ready depends only on registered occupancy, flush and reset. It never depends on the output ready.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full        = (occ_reg == FULL_OCC);
  assign empty       = (occ_reg == '0);
  assign in_ready_o  = rst_i & ~full & ~flush_i;
  assign out_valid_o = ~empty;
  assign out_data_o  = empty ? '0 : mem[rd_ptr_reg];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Compute the next pointers and occupancy. Pointers wrap modulo DEPTH, and a flush returns everything to empty.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      occ_next    = '0;
    end else begin
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_next = occ_reg + 1'b1;
        2'b01:   occ_next = occ_reg - 1'b1;
        default: occ_next = occ_reg;
      endcase
    end
  end

  // Register the pointers and occupancy. Reset empties the FIFO at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Write storage. Stale entries are never visible, because an empty FIFO forces the output to zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data_i;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I encoder for ADDI/LW/SRAI/SW/BEQ.
// The immediate is range-checked at the input. Rejected requests become a NOP flagged with err.
// Results are buffered in a small FIFO, and the module counts the words the consumer takes.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       op_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [31:0]      imm_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  logic [31:0]      enc_word;
  logic             enc_err;
  logic [32:0]      head_data;
  logic [CNT_W-1:0] count_reg;

  // Encode the request. The word defaults to NOP and is replaced only when the operation and immediate are legal.
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b0;
    case (op_e'(op_i))
      OP_ADDI: begin
        if (imm_fits(imm_i, 12)) enc_word = {imm_i[11:0], rs1_i, F3_ADDI, rd_i, OPC_OP_IMM};
        else                     enc_err  = 1'b1;
      end
      OP_LW: begin
        if (imm_fits(imm_i, 12)) enc_word = {imm_i[11:0], rs1_i, F3_LW, rd_i, OPC_LOAD};
        else                     enc_err  = 1'b1;
      end
      OP_SRAI: begin
        if (imm_i[31:5] == 27'd0) enc_word = {F7_SRA, imm_i[4:0], rs1_i, F3_SRAI, rd_i, OPC_OP_IMM};
        else                      enc_err  = 1'b1;
      end
      OP_SW: begin
        if (imm_fits(imm_i, 12)) enc_word = {imm_i[11:5], rs2_i, rs1_i, F3_SW, imm_i[4:0], OPC_STORE};
        else                     enc_err  = 1'b1;
      end
      OP_BEQ: begin
        // A branch offset is a 13-bit even value, so the largest legal offset is 4094.
        if (imm_fits(imm_i, 13) && !imm_i[0])
          enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ, imm_i[4:1], imm_i[11], OPC_BRANCH};
        else
          enc_err = 1'b1;
      end
      default: enc_err = 1'b1;
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (valid_i),
    .in_ready_o  (ready_o),
    .in_data_i   ({enc_err, enc_word}),
    .out_valid_o (valid_o),
    .out_ready_i (ready_i),
    .out_data_o  (head_data)
  );

  assign err_o   = head_data[32];
  assign instr_o = head_data[31:0];
  assign count_o = count_reg;

  // Count words taken by the consumer. Flush does not clear the count, and the count wraps naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else if (valid_o && ready_i) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder.
// Directed requests push expected responses into a queue.
// A negedge monitor pops one entry and compares it each time the DUT hands a word over.
module tb_instr_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic        err_o;
  logic [15:0] count_o;

  instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .rd_i    (rd_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .imm_i   (imm_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .instr_o (instr_o),
    .err_o   (err_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rt;    // round-trip entry: compare the decoded immediate instead of the word
    logic [31:0] word;
    logic        err;
    int          imm;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   mon_pops = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference immediate decoder, as the ID stage applies it.
  function automatic int dec_imm(input logic [31:0] w);
    logic [31:0] v;
    case (w[6:0])
      7'b0010011: v = (w[14:12] == 3'b101) ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
      7'b0000011: v = {{20{w[31]}}, w[31:20]};
      7'b0100011: v = {{20{w[31]}}, w[31:25], w[11:7]};
      7'b1100011: v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default:    v = 32'hDEAD_BEEF;
    endcase
    return int'(v);
  endfunction

  // Monitor: sample just before the handshake edge and pop one expected entry per transfer.
  always @(negedge clk_i) begin : monitor
    exp_t x;
    if (!rst_i) begin
      mon_pops = 0;
    end else if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL unexpected_pop: got %h want no word", instr_o);
      end else begin
        x = sb.pop_front();
        if (x.rt) begin
          chk({x.name, "_imm"}, dec_imm(instr_o), x.imm);
        end else begin
          chk({x.name, "_word"}, instr_o, x.word);
        end
        chk({x.name, "_err"}, {31'd0, err_o}, {31'd0, x.err});
        chk({x.name, "_count"}, {16'd0, count_o}, mon_pops);
        $display("pop %0d %s instr=%h err=%0d count=%0d", mon_pops, x.name, instr_o, err_o, count_o);
      end
      mon_pops++;
    end
  end

  task automatic push(input string name, input int op, input int rd, input int rs1, input int rs2,
                      input int imm, input bit rt, input logic [31:0] w, input logic e);
    exp_t x;
    int   waited;
    waited  = 0;
    op_i    = op[2:0];
    rd_i    = rd[4:0];
    rs1_i   = rs1[4:0];
    rs2_i   = rs2[4:0];
    imm_i   = imm;
    valid_i = 1'b1;
    while (!ready_o && waited < 50) begin
      @(posedge clk_i);
      #1;
      waited++;
    end
    if (!ready_o) begin
      n_cmp++;
      n_mis++;
      $display("FAIL push_timeout %s: got ready_o=0 want 1", name);
      valid_i = 1'b0;
      return;
    end
    x.rt = rt; x.word = w; x.err = e; x.imm = imm; x.name = name;
    sb.push_back(x);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    $display("push %s op=%0d imm=%0d", name, op, imm);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk_i);
    if (sb.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain_timeout %s: got %0d left want 0", name, sb.size());
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, imm;
    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_count", {16'd0, count_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // First word: visible on the cycle after acceptance.
    ready_i = 1'b1;
    push("addi_m1", 0, 5, 1, 0, -1, 0, 32'hFFF0_8293, 1'b0);
    chk("lat_valid", {31'd0, valid_o}, 32'd1);
    chk("lat_instr", instr_o, 32'hFFF0_8293);
    @(posedge clk_i);
    #1;
    chk("lat_count", {16'd0, count_o}, 32'd1);

    push("beq_m4",   4, 0, 1, 2, -4,    0, 32'hFE20_8EE3, 1'b0);
    push("sw_8",     3, 0, 2, 3, 8,     0, 32'h0031_2423, 1'b0);
    push("lw_16",    1, 10, 2, 0, 16,   0, 32'h0101_2503, 1'b0);
    push("srai_3",   2, 6, 6, 0, 3,     0, 32'h4033_5313, 1'b0);
    push("lw_min",   1, 1, 0, 0, -2048, 0, 32'h8000_2083, 1'b0);
    push("beq_min",  4, 0, 0, 0, -4096, 0, 32'h8000_0063, 1'b0);
    push("addi_max", 0, 1, 0, 0, 2047,  0, 32'h7FF0_0093, 1'b0);
    push("addi_2048", 0, 1, 1, 0, 2048, 0, 32'h0000_0013, 1'b1);
    push("beq_odd",  4, 0, 1, 2, 3,     0, 32'h0000_0013, 1'b1);
    push("op6",      6, 1, 1, 1, 0,     0, 32'h0000_0013, 1'b1);
    push("srai_32",  2, 1, 1, 0, 32,    0, 32'h0000_0013, 1'b1);
    push("sw_m2049", 3, 0, 1, 2, -2049, 0, 32'h0000_0013, 1'b1);
    drain("directed");
    chk("count_directed", {16'd0, count_o}, 32'd13);

    // Backpressure: two words fill the FIFO, the third waits until the consumer drains.
    ready_i = 1'b0;
    push("bp_a", 0, 1, 0, 0, 1, 0, 32'h0010_0093, 1'b0);
    push("bp_b", 0, 1, 0, 0, 2, 0, 32'h0020_0093, 1'b0);
    chk("bp_full_ready", {31'd0, ready_o}, 32'd0);
    chk("bp_head", instr_o, 32'h0010_0093);
    ready_i = 1'b1;
    push("bp_c", 0, 1, 0, 0, 3, 0, 32'h0030_0093, 1'b0);
    drain("backpressure");
    chk("count_bp", {16'd0, count_o}, 32'd16);

    // Round trip: random legal fields decode back to the same immediate.
    for (int i = 0; i < 8; i++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        2:       imm = int'($urandom_range(0, 31));
        4:       imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
        default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      push($sformatf("rt%0d", i), op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), imm, 1, 32'd0, 1'b0);
    end
    drain("roundtrip");
    chk("count_rt", {16'd0, count_o}, 32'd24);

    // Flush with one word queued: empty after the next edge, and the count is kept.
    ready_i = 1'b0;
    push("fl_x", 0, 1, 0, 0, 1, 0, 32'h0010_0093, 1'b0);
    chk("fl_valid_before", {31'd0, valid_o}, 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    sb.delete();
    chk("fl_valid", {31'd0, valid_o}, 32'd0);
    chk("fl_instr", instr_o, 32'd0);
    chk("fl_count", {16'd0, count_o}, 32'd24);

    // Reset with one word queued: the output clears without waiting for a clock edge.
    push("rs_y", 0, 1, 0, 0, 2, 0, 32'h0020_0093, 1'b0);
    chk("rs_valid_before", {31'd0, valid_o}, 32'd1);
    #3;
    rst_i = 1'b0;
    #1;
    sb.delete();
    chk("rs_valid", {31'd0, valid_o}, 32'd0);
    chk("rs_instr", instr_o, 32'd0);
    chk("rs_count", {16'd0, count_o}, 32'd0);
    chk("rs_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("rs_ready_after", {31'd0, ready_o}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
